mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two caches and the memory model / top-level memory interface.
- Allows exactly one outstanding transaction at a time.
- Serializes each transaction as an address phase, then BEATS write-data beats or BEATS read-response beats.
- Round-robin arbitration prevents either cache from starving the other.

Parameters:
- ADDR_W, 28, memory request address width (128-bit word address).
- DATA_W, 128, width of one memory data beat.
- BEATS, 4, beats per cache-line transfer. Must be a power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ic_req_valid  input  1  icache line-read request.
- ic_req_ready  output  1  icache request accepted.
- ic_req_addr  input  ADDR_W  icache line address.
- ic_resp_valid  output  1  icache read beat valid.
- ic_resp_data  output  DATA_W  read beat data (shared with dcache).
- dc_req_valid  input  1  dcache request.
- dc_req_ready  output  1  dcache request accepted.
- dc_req_rw  input  1  1 = write, 0 = read.
- dc_req_addr  input  ADDR_W  dcache line address.
- dc_req_data_valid  input  1  dcache write beat valid.
- dc_req_data_ready  output  1  dcache write beat accepted.
- dc_req_data_bits  input  DATA_W  write beat data.
- dc_req_data_mask  input  DATA_W/8  write byte enables.
- dc_resp_valid  output  1  dcache read beat valid.
- dc_resp_data  output  DATA_W  read beat data.
- mem_req_valid  output  1  memory request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_rw  output  1  request type.
- mem_req_addr  output  ADDR_W  request address.
- mem_req_data_valid  output  1  write beat valid.
- mem_req_data_ready  input  1  memory accepts write beat.
- mem_req_data_bits  output  DATA_W  write beat data.
- mem_req_data_mask  output  DATA_W/8  write byte enables.
- mem_resp_valid  input  1  read beat valid.
- mem_resp_data  input  DATA_W  read beat data.

Behaviour:
- Clock and reset: single clock domain clk. Reset is synchronous and active-high on reset.
- Reset values:
  - state = IDLE, beat_cnt = 0, grant = IC, last_grant = DC, so the icache wins the first tie.
  - All valid/ready outputs are 0 during and after reset until a grant is made.
  - Data outputs are don't-care.
- States: IDLE, ADDR, WDATA, RESP.
- IDLE:
  - All handshake outputs are 0.
  - If exactly one *_req_valid is high, register grant to that requester.
  - If both are high, grant the one that is not last_grant.
  - Go to ADDR. Arbitration costs one cycle: a request visible in cycle N drives mem_req_valid in cycle N+1.
- ADDR:
  - mem_req_valid = 1.
  - mem_req_addr and mem_req_rw come from the granted requester; the icache always reads (rw = 0).
  - Granted *_req_ready = mem_req_ready (combinational). The non-granted ready is 0.
  - The requester holds valid and addr stable until ready.
  - On mem_req_valid & mem_req_ready: beat_cnt <= 0. Go to WDATA if rw = 1, else RESP.
- WDATA (dcache writes only):
  - mem_req_data_valid = dc_req_data_valid and dc_req_data_ready = mem_req_data_ready.
  - Data and mask pass through combinationally.
  - Each handshake increments beat_cnt.
  - The handshake with beat_cnt == BEATS-1 goes to IDLE and sets last_grant <= grant.
  - No memory response is expected for writes.
- RESP:
  - Granted *_resp_valid = mem_resp_valid; the other resp_valid is 0.
  - Both resp_data = mem_resp_data.
  - Each valid beat increments beat_cnt.
  - The beat with beat_cnt == BEATS-1 goes to IDLE and updates last_grant.
  - There is no backpressure on responses; caches must accept every beat.
- Minimum gap: one IDLE cycle between consecutive transactions. Back-to-back alternating requests get strict IC/DC alternation.
- Counter width is log2(BEATS). It wraps to 0 only through the IDLE transition and never overflows mid-transfer.
- mem_resp_valid outside RESP is ignored and not forwarded to either cache.
- A request deasserted while granted (protocol violation) does not abort the transaction. The arbiter stays in ADDR until the handshake.
- Reset mid-transaction: immediate return to IDLE, counters cleared, in-flight beats dropped. The memory is reset by the same signal.
- Simultaneous final beat and a new request: the request is held off until the IDLE cycle, then arbitrated with the updated last_grant.

Test Plan:
- Reset, then ic_req_valid = 1, addr = 0x0000010, mem_req_ready = 1 → mem_req_valid high the cycle after request. ic_req_ready pulses for one cycle. 4 mem_resp beats appear on ic_resp_valid only; dc_resp_valid stays 0. Return to IDLE.
- dcache write, addr = 0x00000A0, data beats 0x1..0x4 with mask = all ones, mem_req_data_ready toggling 1,0,1,1,1 → exactly 4 beats forwarded in order, no resp expected, IDLE after beat 4.
- Both requesters valid continuously from reset → grants IC, DC, IC, DC. Each waits at most one transaction.
- mem_req_ready held 0 for 5 cycles in ADDR → mem_req_valid and addr stable, *_req_ready 0, then a single handshake.
- Spurious mem_resp_valid in IDLE and in WDATA → no *_resp_valid asserted, state unchanged.
- reset asserted after read beat 2 → state IDLE next cycle, all valid/ready outputs 0. The next icache request completes a full 4 beats.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single main-memory port between the instruction cache
// (read-only) and the data cache (read/write). At most one transaction is in
// flight: an address phase, then BEATS write-data beats (dcache writes) or
// BEATS read-response beats. Ties are broken round-robin against the
// requester that completed the last transaction, so neither cache can starve
// the other.
//
// Ports
//   clk, reset               : rising-edge clock, synchronous active-high reset
//   ic_req_*                 : icache line-read request (valid/ready/addr)
//   ic_resp_valid/data       : icache read beats
//   dc_req_*                 : dcache request (valid/ready/rw/addr)
//   dc_req_data_*            : dcache write beats (valid/ready/bits/mask)
//   dc_resp_valid/data       : dcache read beats
//   mem_req_*                : memory request (valid/ready/rw/addr)
//   mem_req_data_*           : memory write beats (valid/ready/bits/mask)
//   mem_resp_valid/data      : memory read beats (no backpressure)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  ic_req_valid,
  output logic                  ic_req_ready,
  input  logic [ADDR_W-1:0]     ic_req_addr,
  output logic                  ic_resp_valid,
  output logic [DATA_W-1:0]     ic_resp_data,

  input  logic                  dc_req_valid,
  output logic                  dc_req_ready,
  input  logic                  dc_req_rw,
  input  logic [ADDR_W-1:0]     dc_req_addr,
  input  logic                  dc_req_data_valid,
  output logic                  dc_req_data_ready,
  input  logic [DATA_W-1:0]     dc_req_data_bits,
  input  logic [DATA_W/8-1:0]   dc_req_data_mask,
  output logic                  dc_resp_valid,
  output logic [DATA_W-1:0]     dc_resp_data,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic                  mem_req_data_valid,
  input  logic                  mem_req_data_ready,
  output logic [DATA_W-1:0]     mem_req_data_bits,
  output logic [DATA_W/8-1:0]   mem_req_data_mask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_data
);

  localparam int CNT_W = $clog2(BEATS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_WDATA = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic G_IC = 1'b0;
  localparam logic G_DC = 1'b1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_grant;
  logic             r_last_grant;

  logic w_any_req;
  logic w_next_grant;
  logic w_rw;
  logic w_wbeat;
  logic w_rbeat;
  logic w_last_beat;

  // Arbitration decision for the IDLE cycle. On a tie the requester that did
  // not finish the previous transaction wins.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_grant = G_IC;
    if (ic_req_valid && dc_req_valid) begin
      w_next_grant = ~r_last_grant;
    end else if (dc_req_valid) begin
      w_next_grant = G_DC;
    end
  end

  assign w_any_req   = ic_req_valid | dc_req_valid;
  // The icache is read-only, so only a dcache grant can produce a write.
  assign w_rw        = (r_grant == G_DC) ? dc_req_rw : 1'b0;
  assign w_wbeat     = (r_state == S_WDATA) && dc_req_data_valid && mem_req_data_ready;
  // Response beats count only in RESP; stray memory beats elsewhere are dropped.
  assign w_rbeat     = (r_state == S_RESP) && mem_resp_valid;
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);

  // Address phase: forward the granted request; ready flows straight back.
  assign mem_req_valid = (r_state == S_ADDR);
  assign mem_req_rw    = w_rw;
  assign mem_req_addr  = (r_grant == G_DC) ? dc_req_addr : ic_req_addr;
  assign ic_req_ready  = (r_state == S_ADDR) && (r_grant == G_IC) && mem_req_ready;
  assign dc_req_ready  = (r_state == S_ADDR) && (r_grant == G_DC) && mem_req_ready;

  // Write-data phase: a pure pass-through of the dcache beat handshake.
  assign mem_req_data_valid = (r_state == S_WDATA) && dc_req_data_valid;
  assign dc_req_data_ready  = (r_state == S_WDATA) && mem_req_data_ready;
  assign mem_req_data_bits  = dc_req_data_bits;
  assign mem_req_data_mask  = dc_req_data_mask;

  // Response phase: data fans out to both caches, valid only to the owner.
  assign ic_resp_valid = w_rbeat && (r_grant == G_IC);
  assign dc_resp_valid = w_rbeat && (r_grant == G_DC);
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;

  // Only control state is reset; the data paths are pure pass-throughs and
  // carry no state of their own.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_beat_cnt   <= '0;
      r_grant      <= G_IC;
      r_last_grant <= G_DC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_next_grant;
            r_state <= S_ADDR;
          end
        end

        // The arbiter stays here until the memory handshake, even if the
        // granted requester drops valid in the meantime.
        S_ADDR: begin
          if (mem_req_ready) begin
            r_beat_cnt <= '0;
            r_state    <= w_rw ? S_WDATA : S_RESP;
          end
        end

        S_WDATA: begin
          if (w_wbeat) begin
            if (w_last_beat) begin
              r_beat_cnt   <= '0;
              r_last_grant <= r_grant;
              r_state      <= S_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end

        S_RESP: begin
          if (w_rbeat) begin
            if (w_last_beat) begin
              r_beat_cnt   <= '0;
              r_last_grant <= r_grant;
              r_state      <= S_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scoreboard bench for mem_arbiter. Requests, write beats and read beats are
// pushed as expectations when the stimulus is driven; a negedge monitor pops
// and compares them when the DUT produces the matching output. A small
// cycle-based memory model answers requests with configurable address-phase
// stall, write-ready pattern, response bubble and spurious response beats.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int BEATS  = 4;
  localparam int MASK_W = DATA_W / 8;
  localparam int CW     = 160;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               ic_req_valid, ic_req_ready;
  logic [ADDR_W-1:0]  ic_req_addr;
  logic               ic_resp_valid;
  logic [DATA_W-1:0]  ic_resp_data;
  logic               dc_req_valid, dc_req_ready, dc_req_rw;
  logic [ADDR_W-1:0]  dc_req_addr;
  logic               dc_req_data_valid, dc_req_data_ready;
  logic [DATA_W-1:0]  dc_req_data_bits;
  logic [MASK_W-1:0]  dc_req_data_mask;
  logic               dc_resp_valid;
  logic [DATA_W-1:0]  dc_resp_data;
  logic               mem_req_valid, mem_req_ready, mem_req_rw;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_req_data_valid, mem_req_data_ready;
  logic [DATA_W-1:0]  mem_req_data_bits;
  logic [MASK_W-1:0]  mem_req_data_mask;
  logic               mem_resp_valid;
  logic [DATA_W-1:0]  mem_resp_data;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk               (clk),
    .reset             (reset),
    .ic_req_valid      (ic_req_valid),
    .ic_req_ready      (ic_req_ready),
    .ic_req_addr       (ic_req_addr),
    .ic_resp_valid     (ic_resp_valid),
    .ic_resp_data      (ic_resp_data),
    .dc_req_valid      (dc_req_valid),
    .dc_req_ready      (dc_req_ready),
    .dc_req_rw         (dc_req_rw),
    .dc_req_addr       (dc_req_addr),
    .dc_req_data_valid (dc_req_data_valid),
    .dc_req_data_ready (dc_req_data_ready),
    .dc_req_data_bits  (dc_req_data_bits),
    .dc_req_data_mask  (dc_req_data_mask),
    .dc_resp_valid     (dc_resp_valid),
    .dc_resp_data      (dc_resp_data),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_rw        (mem_req_rw),
    .mem_req_addr      (mem_req_addr),
    .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits (mem_req_data_bits),
    .mem_req_data_mask (mem_req_data_mask),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              dst;   // 0 = icache, 1 = dcache
    logic              rw;
    logic [ADDR_W-1:0] addr;
  } req_exp_t;

  typedef struct packed {
    logic              dst;
    logic [DATA_W-1:0] data;
  } rsp_exp_t;

  typedef struct packed {
    logic [DATA_W-1:0] bits;
    logic [MASK_W-1:0] mask;
  } wr_exp_t;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];
  wr_exp_t  wr_q[$];

  int n_checks    = 0;
  int n_errors    = 0;
  int rsp_seen    = 0;
  int wbeats_seen = 0;

  // Memory model knobs.
  int         stall_cfg  = 0;        // 0: ready held high while idle
  logic [4:0] wr_pat     = 5'b11101; // write-ready per cycle: 1,0,1,1,1
  logic       rsp_bubble = 1'b0;
  logic       spurious   = 1'b0;

  localparam logic [DATA_W-1:0] JUNK = {4{32'hDEADBEEF}};

  task automatic check(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input logic [ADDR_W-1:0] a, input int b);
    return {96'(a), 32'h5A5A0000 | 32'(b)};
  endfunction

  // ---------------------------------------------------------------- memory --
  initial begin : mem_model
    int m_state, m_stall, m_beat, m_idx;
    logic [ADDR_W-1:0] m_addr, s_addr;
    logic s_rst, s_valid, s_req, s_rw, s_wbeat, s_rbeat, bubbled;
    m_state = 0; m_stall = 0; m_beat = 0; m_idx = 0; m_addr = '0; bubbled = 1'b0;
    mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    forever begin
      @(negedge clk);
      s_rst   = reset;
      s_valid = mem_req_valid;
      s_req   = mem_req_valid && mem_req_ready;
      s_rw    = mem_req_rw;
      s_addr  = mem_req_addr;
      s_wbeat = mem_req_data_valid && mem_req_data_ready;
      s_rbeat = mem_resp_valid;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      if (s_rst) begin
        m_state = 0; m_stall = 0;
        mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
      end else begin
        if (m_state != 0 && (m_state == 1 ? s_rbeat : s_wbeat)) m_beat++;
        if (m_state != 0 && m_beat >= BEATS) begin
          m_state = 0; m_stall = 0;
        end
        if (m_state == 0 && s_req) begin
          m_state = s_rw ? 2 : 1;
          m_beat = 0; m_idx = 0; m_stall = 0; m_addr = s_addr; bubbled = 1'b0;
        end
        case (m_state)
          1: begin
            mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
            if (rsp_bubble && m_beat == 1 && !bubbled) begin
              bubbled = 1'b1;
            end else begin
              mem_resp_valid = 1'b1;
              mem_resp_data  = mk_data(m_addr, m_beat);
            end
          end
          2: begin
            mem_req_ready = 1'b0;
            mem_req_data_ready = (m_idx < 5) ? wr_pat[m_idx] : 1'b1;
            m_idx++;
          end
          default: begin
            mem_req_data_ready = 1'b0;
            if (stall_cfg == 0) begin
              mem_req_ready = 1'b1;
            end else if (s_valid) begin
              m_stall++;
              mem_req_ready = (m_stall >= stall_cfg);
            end else begin
              mem_req_ready = 1'b0;
            end
          end
        endcase
        if (spurious && m_state != 1) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = JUNK;
        end
      end
    end
  end

  // --------------------------------------------------------------- monitor --
  always @(negedge clk) begin : monitor
    req_exp_t e;
    rsp_exp_t r;
    wr_exp_t  w;
    if (!reset) begin
      if (mem_req_valid && mem_req_ready) begin
        check("req_expected", CW'(req_q.size() > 0), CW'(1));
        if (req_q.size() > 0) begin
          e = req_q.pop_front();
          check("req_rw_addr", CW'({mem_req_rw, mem_req_addr}), CW'({e.rw, e.addr}));
          check("req_ready_route", CW'({ic_req_ready, dc_req_ready}), CW'(e.dst ? 2'b01 : 2'b10));
        end
      end
      if (ic_resp_valid || dc_resp_valid) begin
        check("rsp_expected", CW'(rsp_q.size() > 0), CW'(1));
        if (rsp_q.size() > 0) begin
          r = rsp_q.pop_front();
          check("rsp_route", CW'({ic_resp_valid, dc_resp_valid}), CW'(r.dst ? 2'b01 : 2'b10));
          check("rsp_data", CW'(r.dst ? dc_resp_data : ic_resp_data), CW'(r.data));
          rsp_seen++;
        end
      end
      if (mem_req_data_valid && mem_req_data_ready) begin
        check("wr_expected", CW'(wr_q.size() > 0), CW'(1));
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          check("wr_bits", CW'(mem_req_data_bits), CW'(w.bits));
          check("wr_mask", CW'(mem_req_data_mask), CW'(w.mask));
          wbeats_seen++;
        end
      end
    end
  end

  // ----------------------------------------------------------------- tasks --
  task automatic check_idle(input string tag);
    check(tag, CW'({mem_req_valid, mem_req_data_valid, ic_req_ready, dc_req_ready,
                    dc_req_data_ready, ic_resp_valid, dc_resp_valid}), CW'(0));
  endtask

  task automatic push_read(input logic dst, input logic [ADDR_W-1:0] a);
    req_q.push_back('{dst: dst, rw: 1'b0, addr: a});
    for (int k = 0; k < BEATS; k++) rsp_q.push_back('{dst: dst, data: mk_data(a, k)});
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    while ((rsp_q.size() + req_q.size() + wr_q.size()) != 0 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check({tag, "_drain"}, CW'(rsp_q.size() + req_q.size() + wr_q.size()), CW'(0));
    repeat (2) @(negedge clk);
    check_idle({tag, "_idle"});
  endtask

  task automatic ic_read(input logic [ADDR_W-1:0] a, input string tag);
    int cyc;
    push_read(1'b0, a);
    @(posedge clk); #1;
    ic_req_valid = 1'b1;
    ic_req_addr  = a;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!ic_req_ready && cyc < 50);
    check({tag, "_req_hs"}, CW'(ic_req_ready), CW'(1));
    @(posedge clk); #1;
    ic_req_valid = 1'b0;
  endtask

  task automatic dc_write(input logic [ADDR_W-1:0] a, input logic rnd, input string tag);
    wr_exp_t w;
    int cyc, base;
    base = wbeats_seen;
    req_q.push_back('{dst: 1'b1, rw: 1'b1, addr: a});
    @(posedge clk); #1;
    dc_req_valid = 1'b1;
    dc_req_rw    = 1'b1;
    dc_req_addr  = a;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!dc_req_ready && cyc < 50);
    check({tag, "_req_hs"}, CW'(dc_req_ready), CW'(1));
    @(posedge clk); #1;
    dc_req_valid = 1'b0;
    dc_req_rw    = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      w.bits = rnd ? {$urandom, $urandom, $urandom, $urandom} : DATA_W'(k + 1);
      w.mask = rnd ? MASK_W'($urandom) : '1;
      wr_q.push_back(w);
      dc_req_data_valid = 1'b1;
      dc_req_data_bits  = w.bits;
      dc_req_data_mask  = w.mask;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!dc_req_data_ready && cyc < 50);
      check({tag, "_beat_hs"}, CW'(dc_req_data_ready), CW'(1));
      @(posedge clk); #1;
    end
    dc_req_data_valid = 1'b0;
    drain(tag);
    check({tag, "_beats"}, CW'(wbeats_seen - base), CW'(BEATS));
  endtask

  // -------------------------------------------------------------- watchdog --
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ------------------------------------------------------------------ main --
  initial begin
    int cyc, base;
    ic_req_valid = 1'b0; ic_req_addr = '0;
    dc_req_valid = 1'b0; dc_req_rw = 1'b0; dc_req_addr = '0;
    dc_req_data_valid = 1'b0; dc_req_data_bits = '0; dc_req_data_mask = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_idle("reset_idle");
    @(posedge clk); #1;
    reset = 1'b0;

    // Icache read: one arbitration cycle, one-cycle ready pulse, 4 ic beats.
    push_read(1'b0, 28'h0000010);
    @(posedge clk); #1;
    ic_req_valid = 1'b1;
    ic_req_addr  = 28'h0000010;
    @(negedge clk);
    check("t1_arb_cycle", CW'({mem_req_valid, ic_req_ready}), CW'(0));
    @(negedge clk);
    check("t1_addr_phase", CW'({mem_req_valid, ic_req_ready, dc_req_ready, mem_req_rw}), CW'(4'b1100));
    check("t1_addr", CW'(mem_req_addr), CW'(28'h0000010));
    @(posedge clk); #1;
    ic_req_valid = 1'b0;
    @(negedge clk);
    check("t1_ready_pulse", CW'(ic_req_ready), CW'(0));
    drain("t1");

    // Dcache write with toggling write-ready.
    dc_write(28'h00000A0, 1'b0, "t2");

    // Both requesters valid from reset: strict IC/DC alternation.
    @(posedge clk); #1;
    reset = 1'b1;
    ic_req_valid = 1'b1; ic_req_addr = 28'h100;
    dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 28'h200;
    rsp_bubble = 1'b1;
    push_read(1'b0, 28'h100);
    push_read(1'b1, 28'h200);
    push_read(1'b0, 28'h110);
    push_read(1'b1, 28'h210);
    repeat (2) @(negedge clk);
    check_idle("t3_reset_hold");
    @(posedge clk); #1;
    reset = 1'b0;
    fork
      begin : ic_agent
        int c;
        for (int i = 0; i < 2; i++) begin
          ic_req_addr  = (i == 0) ? 28'h100 : 28'h110;
          ic_req_valid = 1'b1;
          c = 0;
          do begin @(negedge clk); c++; end while (!ic_req_ready && c < 200);
          check("t3_ic_hs", CW'(ic_req_ready), CW'(1));
          @(posedge clk); #1;
        end
        ic_req_valid = 1'b0;
      end
      begin : dc_agent
        int c;
        for (int i = 0; i < 2; i++) begin
          dc_req_addr  = (i == 0) ? 28'h200 : 28'h210;
          dc_req_valid = 1'b1;
          c = 0;
          do begin @(negedge clk); c++; end while (!dc_req_ready && c < 200);
          check("t3_dc_hs", CW'(dc_req_ready), CW'(1));
          @(posedge clk); #1;
        end
        dc_req_valid = 1'b0;
      end
    join
    drain("t3");
    rsp_bubble = 1'b0;

    // Address phase stalled for 5 cycles by the memory.
    stall_cfg = 5;
    push_read(1'b0, 28'h300);
    @(posedge clk); #1;
    ic_req_valid = 1'b1;
    ic_req_addr  = 28'h300;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall", CW'({mem_req_valid, ic_req_ready, dc_req_ready, mem_req_addr}),
            CW'({3'b100, 28'h300}));
    end
    @(negedge clk);
    check("t4_hs", CW'({mem_req_valid, ic_req_ready}), CW'(2'b11));
    @(posedge clk); #1;
    ic_req_valid = 1'b0;
    drain("t4");
    stall_cfg = 0;

    // Spurious memory responses in IDLE and during a write.
    spurious = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_idle("t5_idle_spurious");
    end
    dc_write(28'h00000B0, 1'b1, "t5");
    spurious = 1'b0;

    // Reset after the second read beat, then a clean full read.
    base = rsp_seen;
    ic_read(28'h400, "t6a");
    cyc = 0;
    while (rsp_seen < base + 2 && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("t6_two_beats", CW'(rsp_seen - base), CW'(2));
    @(posedge clk); #1;
    reset = 1'b1;
    rsp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_idle("t6_after_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    base = rsp_seen;
    ic_read(28'h410, "t6b");
    drain("t6b");
    check("t6b_beats", CW'(rsp_seen - base), CW'(BEATS));

    check("final_queues", CW'(req_q.size() + rsp_q.size() + wr_q.size()), CW'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
